key_sweep_gen: RTL and testbench
================================

# key_sweep_gen

Brute-force key candidate generator that sits directly upstream of the key-compare/logging stage in the modchip attack experiment. It drives successive 8-bit candidates onto the compare stage's key input, holds each for a fixed dwell, and samples the compare stage's match feedback. It latches the first matching key, or flags exhaustion after all 256 values fail.

## Interface
Parameters:
- KEY_W, 8, candidate/key width.
- DWELL, 4, cycles each candidate is held; legal range DWELL >= MATCH_LAT+1.
- MATCH_LAT, 1, cycles from key_out change to valid match_in. The downstream compare is registered.

Ports:
- clk  in  1  system clock (50 MHz board clock).
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a sweep from candidate 0. Ignored while busy.
- abort  in  1  terminates an active sweep.
- match_in  in  1  match feedback from the compare stage (OR of its LED bus).
- key_out  out  KEY_W  candidate driven to the compare stage.
- key_valid  out  1  key_out carries a live candidate or a found key.
- busy  out  1  sweep in progress.
- found  out  1  a match was latched; sticky until start or rst.
- exhausted  out  1  all 2^KEY_W candidates failed; sticky until start or rst.
- found_key  out  KEY_W  latched matching candidate.
- attempts  out  KEY_W+1  number of candidates evaluated; range 0..256.

## Operation
- States:
  - IDLE: key_out=0, key_valid=0, busy=0.
  - DRIVE: busy=1, key_valid=1, key_out=cand.
  - FOUND: key_out=found_key, key_valid=1, found=1. The found key stays applied so the downstream LEDs stay lit.
  - EXHAUST: key_valid=0, key_out=0, exhausted=1.
- Transitions from IDLE, FOUND or EXHAUST:
  - start moves to DRIVE.
  - On entry to DRIVE: cand=0, dwell=0, attempts=0, found=0, exhausted=0, found_key=0.
- DRIVE dwell counting:
  - dwell counts 0..DWELL-1.
  - The evaluation cycle is dwell==DWELL-1. match_in is sampled only on that cycle; match_in at any other time is ignored.
- DRIVE evaluation, checked in this priority order:
  - abort (any DRIVE cycle): go to IDLE. Flags and attempts are not updated. abort beats a same-cycle match.
  - Evaluation with match_in=1: attempts+1, found_key=cand, go to FOUND.
  - Evaluation with match_in=0 and cand=2^KEY_W-1: attempts+1, go to EXHAUST.
  - Otherwise: attempts+1, cand+1, dwell=0.
- Arithmetic:
  - cand is KEY_W bits and never wraps. The terminal candidate goes to EXHAUST.
  - attempts is KEY_W+1 bits so that 256 is representable.
- abort outside DRIVE has no effect.
- start while busy is ignored. start and abort in the same cycle while idle: start wins.
- rst has priority over everything and is legal mid-sweep. Reset values: state IDLE; key_out 0, key_valid 0, busy 0, found 0, exhausted 0, found_key 0, attempts 0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Let E0 be the edge that samples start:
  - After E0: key_out=0, key_valid=1, busy=1.
  - Candidate c is held from edge E0+c·DWELL through E0+(c+1)·DWELL.
  - match_in for candidate c is sampled at edge E0+(c+1)·DWELL.
- Key k found: found=1, found_key=k and attempts=k+1 are visible after edge E0+(k+1)·DWELL. busy drops at the same edge.
- No match: exhausted=1 and attempts=256 after edge E0+256·DWELL (1024 edges with the default DWELL).
- abort sampled at edge A: busy=0, key_valid=0 after A.
- Correct detection requires DWELL >= MATCH_LAT+1. Elaboration fails otherwise.

## Structure
- Package key_sweep_pkg holds:
  - the state enum (IDLE, DRIVE, FOUND, EXHAUST);
  - the default KEY_W constant;
  - the derived ATTEMPT_W = KEY_W+1.
- Single module. The dwell counter and candidate counter are inline; no sub-module is warranted.
- Top-level hookup: key_out feeds the compare stage's key_in; match_in = |led.

## Test plan
- Compare key 0x00, DWELL=4: start at E0 -> found=1, found_key=0x00, attempts=1 after E0+4; key_out stays 0x00.
- Compare key 0x3D: found after E0+248, found_key=0x3D, attempts=62, busy=0 at the same edge.
- No matching key (match_in tied 0): exhausted=1 after E0+1024, attempts=256, key_valid=0, found=0.
- abort while cand=0x10, simultaneous with match_in=1 on the evaluation cycle -> IDLE, found=0, attempts=16. A new start restarts from 0x00.
- match_in pulsed on dwell=1 for cand 0x05 only -> ignored, sweep continues. start pulsed while busy -> no restart.
- rst asserted mid-sweep at cand 0x80 -> next cycle all outputs 0, IDLE. After rst is released, start sweeps from 0x00 normally.

Source files
------------

// File: rtl/key_sweep_pkg.sv
// Shared types and default widths for the brute-force key sweep generator.
package key_sweep_pkg;

  localparam int KEY_W_DEFAULT = 8;
  localparam int ATTEMPT_W     = KEY_W_DEFAULT + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    FOUND   = 2'd2,
    EXHAUST = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/key_sweep_gen.sv
// Drives successive key candidates to a registered compare stage, holds each for
// DWELL cycles, and latches the first candidate whose match feedback is seen.
module key_sweep_gen
  import key_sweep_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEFAULT,
  parameter int DWELL     = 4,
  parameter int MATCH_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             match_in,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] found_key,
  output logic [KEY_W:0]   attempts
);

  localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [KEY_W-1:0]  CAND_LAST  = {KEY_W{1'b1}};

  // The compare result must have settled before the evaluation cycle samples it.
  if (DWELL < MATCH_LAT + 1) begin : g_bad_dwell
    $error("key_sweep_gen: DWELL must be at least MATCH_LAT+1");
  end

  sweep_state_t     state_r;
  logic [KEY_W-1:0] cand_r;
  logic [DW_W-1:0]  dwell_r;

  // Sweep state machine; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cand_r    <= '0;
      dwell_r   <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      found_key <= '0;
      attempts  <= '0;
    end else begin
      case (state_r)
        IDLE, FOUND, EXHAUST: begin
          if (start) begin
            state_r   <= DRIVE;
            cand_r    <= '0;
            dwell_r   <= '0;
            key_out   <= '0;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            found     <= 1'b0;
            exhausted <= 1'b0;
            found_key <= '0;
            attempts  <= '0;
          end else begin
            state_r <= state_r;
          end
        end

        DRIVE: begin
          if (abort) begin
            // Abort wins even over a match sampled on the same edge.
            state_r   <= IDLE;
            key_out   <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (dwell_r == DWELL_LAST) begin
            attempts <= attempts + (KEY_W + 1)'(1);
            if (match_in) begin
              state_r   <= FOUND;
              found     <= 1'b1;
              found_key <= cand_r;
              key_out   <= cand_r;
              key_valid <= 1'b1;
              busy      <= 1'b0;
            end else if (cand_r == CAND_LAST) begin
              state_r   <= EXHAUST;
              exhausted <= 1'b1;
              key_out   <= '0;
              key_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              cand_r  <= cand_r + KEY_W'(1);
              key_out <= cand_r + KEY_W'(1);
              dwell_r <= '0;
            end
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
          end
        end

        default: begin
          state_r   <= IDLE;
          key_out   <= '0;
          key_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sweep_gen.sv
// Directed bench: a registered compare-stage model feeds match_in back to the sweep.
module tb_key_sweep_gen;

  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          match_in;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic [KW-1:0] found_key;
  logic [KW:0]   attempts;

  // Compare-stage model: one registered cycle of latency, plus a forced pulse.
  logic          cmp_en;
  logic [KW-1:0] cmp_key;
  logic          cmp_q;
  logic          force_match;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  always_ff @(posedge clk) cmp_q <= cmp_en && key_valid && (key_out == cmp_key);
  assign match_in = cmp_q | force_match;

  key_sweep_gen #(.KEY_W(KW), .DWELL(4), .MATCH_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .match_in(match_in),
    .key_out(key_out), .key_valid(key_valid), .busy(busy), .found(found),
    .exhausted(exhausted), .found_key(found_key), .attempts(attempts)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pulse start so that the returned edge is E0.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count edges after E0 until busy falls; bounded so a stuck DUT still ends.
  task automatic wait_done(input string name, output int n);
    n = 0;
    while (busy && n < 1100) begin
      step();
      n++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: busy still 1 after %0d edges, expected 0", name, n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_out"}, int'(key_out), 0);
    check({tag, "_key_valid"}, int'(key_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_found"}, int'(found), 0);
    check({tag, "_exhausted"}, int'(exhausted), 0);
    check({tag, "_found_key"}, int'(found_key), 0);
    check({tag, "_attempts"}, int'(attempts), 0);
  endtask

  typedef struct {
    string         name;
    logic          en;
    logic [KW-1:0] target;
    logic          exp_found;
    logic          exp_exh;
    int            exp_key;
    int            exp_att;
    int            exp_edges;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cmp_en = 1'b0; cmp_key = '0; force_match = 1'b0;
    steps(2);
    check_all_zero("reset");
    rst = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle_busy", int'(busy), 0);

    vecs[0] = '{"key00", 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1,   4};
    vecs[1] = '{"key3d", 1'b1, 8'h3D, 1'b1, 1'b0, 8'h3D, 62,  248};
    vecs[2] = '{"key01", 1'b1, 8'h01, 1'b1, 1'b0, 8'h01, 2,   8};
    vecs[3] = '{"keyff", 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 256, 1024};
    vecs[4] = '{"nokey", 1'b0, 8'hAA, 1'b0, 1'b1, 8'h00, 256, 1024};

    // Back-to-back sweeps also cover restarting from FOUND and EXHAUST.
    for (int v = 0; v < 5; v++) begin
      cmp_en  = vecs[v].en;
      cmp_key = vecs[v].target;
      step();
      pulse_start();
      check({vecs[v].name, "_e0_busy"}, int'(busy), 1);
      check({vecs[v].name, "_e0_key_valid"}, int'(key_valid), 1);
      check({vecs[v].name, "_e0_key_out"}, int'(key_out), 0);
      check({vecs[v].name, "_e0_flags"}, int'({found, exhausted}), 0);
      wait_done(vecs[v].name, n);
      check({vecs[v].name, "_edges"}, n, vecs[v].exp_edges);
      check({vecs[v].name, "_found"}, int'(found), int'(vecs[v].exp_found));
      check({vecs[v].name, "_exhausted"}, int'(exhausted), int'(vecs[v].exp_exh));
      check({vecs[v].name, "_found_key"}, int'(found_key), vecs[v].exp_key);
      check({vecs[v].name, "_attempts"}, int'(attempts), vecs[v].exp_att);
      check({vecs[v].name, "_key_valid"}, int'(key_valid), int'(vecs[v].exp_found));
      check({vecs[v].name, "_key_out"}, int'(key_out), vecs[v].exp_found ? vecs[v].exp_key : 0);
      steps(3);
      check({vecs[v].name, "_hold_key_out"}, int'(key_out), vecs[v].exp_found ? vecs[v].exp_key : 0);
      check({vecs[v].name, "_hold_found"}, int'(found), int'(vecs[v].exp_found));
    end

    // Abort on the evaluation edge of cand 0x10 while match_in is high.
    cmp_en = 1'b1; cmp_key = 8'h10;
    pulse_start();
    steps(67);
    check("abort_pre_key_out", int'(key_out), 16);
    check("abort_pre_match_in", int'(match_in), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_key_valid", int'(key_valid), 0);
    check("abort_key_out", int'(key_out), 0);
    check("abort_found", int'(found), 0);
    check("abort_attempts", int'(attempts), 16);
    cmp_key = 8'h02;
    pulse_start();
    check("restart_key_out", int'(key_out), 0);
    check("restart_attempts", int'(attempts), 0);
    wait_done("restart", n);
    check("restart_edges", n, 12);
    check("restart_found_key", int'(found_key), 2);
    check("restart_attempts_done", int'(attempts), 3);

    // Off-evaluation match pulse on cand 0x05 and a start while busy are both ignored.
    cmp_key = 8'h07;
    pulse_start();
    steps(9);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_key_out", int'(key_out), 2);
    steps(11);
    check("pulse_pre_key_out", int'(key_out), 5);
    force_match = 1'b1;
    step();
    force_match = 1'b0;
    check("pulse_busy", int'(busy), 1);
    check("pulse_found", int'(found), 0);
    steps(2);
    check("pulse_next_key_out", int'(key_out), 6);
    n = 0;
    while (busy && n < 1100) begin
      step();
      n++;
    end
    check("pulse_edges", n + 24, 32);
    check("pulse_found_key", int'(found_key), 7);
    check("pulse_attempts", int'(attempts), 8);

    // Reset in the middle of cand 0x80, then a clean sweep.
    cmp_key = 8'h03;
    cmp_en = 1'b0;
    pulse_start();
    steps(514);
    check("rst_pre_key_out", int'(key_out), 128);
    check("rst_pre_attempts", int'(attempts), 128);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    cmp_en = 1'b1;
    pulse_start();
    check("postrst_key_out", int'(key_out), 0);
    check("postrst_busy", int'(busy), 1);
    wait_done("postrst", n);
    check("postrst_edges", n, 16);
    check("postrst_found_key", int'(found_key), 3);
    check("postrst_attempts", int'(attempts), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
